// File: rtl/pipe_defs.sv
// Shared pipeline definitions: forward-select encodings, Tuse sentinel,
// md-unit latencies and a couple of hazard helpers.
package pipe_defs;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // A source with this Tuse is never read, so no Tnew can exceed it.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W        = 4;

  localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;

  // Pending write of a later stage.
  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } pend_wr_t;

  // Result not ready in time for the consumer: must stall.
  function automatic logic wr_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                     input pend_wr_t wr);
    return (src != 5'd0) && (src == wr.a3) && (wr.tnew > tuse);
  endfunction

  // Result ready now in that stage: can be forwarded.
  function automatic logic wr_ready(input logic [4:0] src, input pend_wr_t wr);
    return (src != 5'd0) && (src == wr.a3) && (wr.tnew == 2'd0);
  endfunction

  // Nearest qualifying stage wins.
  function automatic logic [1:0] fwd_pick(input logic e_hit, input logic m_hit,
                                          input logic w_hit);
    if (e_hit)      return FWD_E;
    else if (m_hit) return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_seq.sv
// Busy sequencer of the multi-cycle mult/div unit: IDLE/BUSY with a down-counter.
module md_busy_seq
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]          state;
  logic [MD_CNT_W-1:0] cnt;

  // Load the latency on start; count down and return to IDLE on the last busy cycle.
  // A start seen while BUSY is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_BUSY;
          cnt   <= div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end
        default: begin
          cnt <= cnt - MD_CNT_W'(1);
          if (cnt == MD_CNT_W'(1)) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / forward-select controller for the five-stage pipeline,
// plus md-unit busy tracking and a stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [4:0]  W_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic [4:0]  E_rs,
  input  logic [4:0]  E_rt,
  input  logic [4:0]  M_rt,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        E_flush,
  output logic        md_busy,
  output logic [1:0]  D_fwd_rs,
  output logic [1:0]  D_fwd_rt,
  output logic [1:0]  E_fwd_rs,
  output logic [1:0]  E_fwd_rt,
  output logic        M_fwd_rt,
  output logic [31:0] stall_cnt
);

  pend_wr_t e_wr, m_wr, w_wr;
  logic     data_stall, md_stall;

  assign e_wr = '{a3: E_A3, tnew: E_Tnew};
  assign m_wr = '{a3: M_A3, tnew: M_Tnew};
  assign w_wr = '{a3: W_A3, tnew: 2'd0};   // W results are always ready

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (E_md_start),
    .div   (E_md_div),
    .busy  (md_busy)
  );

  // Stall: a D source whose producer in E/M is not ready in time, or an md
  // instruction meeting an occupied (or just-starting) md unit.
  always_comb begin
    data_stall = wr_hazard(D_rs, D_Tuse_rs, e_wr) || wr_hazard(D_rs, D_Tuse_rs, m_wr) ||
                 wr_hazard(D_rt, D_Tuse_rt, e_wr) || wr_hazard(D_rt, D_Tuse_rt, m_wr);
    md_stall   = D_md && (md_busy || E_md_start);
  end

  assign stall   = data_stall | md_stall;
  assign E_flush = stall;

  // Forward selects, nearest ready producer first.
  always_comb begin
    D_fwd_rs = fwd_pick(wr_ready(D_rs, e_wr), wr_ready(D_rs, m_wr), wr_ready(D_rs, w_wr));
    D_fwd_rt = fwd_pick(wr_ready(D_rt, e_wr), wr_ready(D_rt, m_wr), wr_ready(D_rt, w_wr));
    E_fwd_rs = fwd_pick(1'b0, wr_ready(E_rs, m_wr), wr_ready(E_rs, w_wr));
    E_fwd_rt = fwd_pick(1'b0, wr_ready(E_rt, m_wr), wr_ready(E_rt, w_wr));
    M_fwd_rt = wr_ready(M_rt, w_wr);
  end

  // Count stalled cycles; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3, W_A3, E_rs, E_rt, M_rt;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_md, E_md_start, E_md_div;
  logic        stall, E_flush, md_busy, M_fwd_rt;
  logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_md(D_md),
    .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_rs(E_rs), .E_rt(E_rt), .M_rt(M_rt), .E_md_start(E_md_start), .E_md_div(E_md_div),
    .stall(stall), .E_flush(E_flush), .md_busy(md_busy),
    .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt), .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt),
    .M_fwd_rt(M_fwd_rt), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_md = 0;
    E_A3 = 0; M_A3 = 0; W_A3 = 0; E_Tnew = 0; M_Tnew = 0;
    E_rs = 0; E_rt = 0; M_rt = 0; E_md_start = 0; E_md_div = 0;
  endtask

  // Run an md start with D_md held; count busy and stall cycles.
  task automatic md_run(input logic div, input int exp_busy, input string tag);
    int busy_n, stall_n;
    logic [31:0] s0;
    s0 = stall_cnt;
    D_md = 1; E_md_start = 1; E_md_div = div;
    #1;
    chk({tag, "_start_stall"}, stall, 1);
    stall_n = stall ? 1 : 0;
    busy_n = 0;
    tick();
    E_md_start = 0;
    for (int i = 0; i < 20; i++) begin
      if (md_busy) busy_n++;
      if (stall) stall_n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, busy_n, exp_busy);
    chk({tag, "_stall_cycles"}, stall_n, exp_busy + 1);
    chk({tag, "_stall_cnt"}, stall_cnt - s0, exp_busy + 1);
    D_md = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    #2;
    chk("rst_busy", md_busy, 0);
    chk("rst_cnt", stall_cnt, 0);
    // combinational path is live during reset, counter is not
    E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 0;
    #1;
    chk("rst_comb_stall", stall, 1);
    tick();
    chk("rst_cnt_held", stall_cnt, 0);
    idle_inputs();
    #1;
    reset = 1;
    tick();

    // E data stall held 3 cycles
    E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 0;
    #1;
    chk("e_stall", stall, 1);
    chk("e_flush", E_flush, 1);
    tick(); tick(); tick();
    chk("e_stall_cnt", stall_cnt, 3);

    // Tnew == Tuse: no stall
    E_Tnew = 1; D_Tuse_rs = 1;
    #1;
    chk("tnew_eq_tuse", stall, 0);

    // M hazard on rt
    idle_inputs();
    M_A3 = 12; M_Tnew = 1; D_rt = 12; D_Tuse_rt = 0;
    #1;
    chk("m_stall_rt", stall, 1);
    D_Tuse_rt = 2'd3;
    #1;
    chk("m_unused_rt", stall, 0);

    // W never stalls
    idle_inputs();
    W_A3 = 4; D_rs = 4; D_Tuse_rs = 0;
    #1;
    chk("w_no_stall", stall, 0);
    chk("d_fwd_w", D_fwd_rs, 3);

    // E beats M
    idle_inputs();
    E_A3 = 8; E_Tnew = 0; M_A3 = 8; M_Tnew = 0; D_rs = 8; D_Tuse_rs = 0;
    #1;
    chk("d_fwd_e", D_fwd_rs, 1);
    chk("d_fwd_e_nostall", stall, 0);
    // E not ready (and not a hazard at Tuse 1): M supplies
    E_Tnew = 1; D_Tuse_rs = 1;
    #1;
    chk("d_fwd_m", D_fwd_rs, 2);
    chk("d_fwd_m_nostall", stall, 0);
    // rt path from W while rs unaffected
    D_rt = 9; W_A3 = 9;
    #1;
    chk("d_fwd_rt_w", D_fwd_rt, 3);

    // register 0
    idle_inputs();
    D_rs = 0; D_Tuse_rs = 0; E_A3 = 0; E_Tnew = 2;
    #1;
    chk("r0_stall", stall, 0);
    chk("r0_fwd", D_fwd_rs, 0);

    // E/M stage forwarding
    idle_inputs();
    E_rs = 5; M_A3 = 5; M_Tnew = 0; W_A3 = 5;
    #1;
    chk("e_fwd_rs_m", E_fwd_rs, 2);
    M_Tnew = 1;
    #1;
    chk("e_fwd_rs_w", E_fwd_rs, 3);
    E_rt = 5;
    #1;
    chk("e_fwd_rt_w", E_fwd_rt, 3);
    M_rt = 5;
    #1;
    chk("m_fwd_rt", M_fwd_rt, 1);
    M_rt = 0; W_A3 = 0;
    #1;
    chk("m_fwd_rt_r0", M_fwd_rt, 0);
    chk("e_fwd_rf", E_fwd_rs, 0);

    // md sequence: mult
    idle_inputs();
    #1;
    md_run(1'b0, 5, "mult");

    // div then asynchronous reset mid-busy
    E_md_start = 1; E_md_div = 1;
    tick();
    E_md_start = 0;
    chk("div_busy", md_busy, 1);
    tick(); tick();
    chk("div_busy3", md_busy, 1);
    reset = 0;
    #1;
    chk("div_rst_busy", md_busy, 0);
    chk("div_rst_cnt", stall_cnt, 0);
    #2;
    reset = 1;
    tick();
    chk("post_rst_idle", md_busy, 0);
    md_run(1'b0, 5, "mult2");

    // wrap of stall counter
    idle_inputs();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    #1;
    E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 0;
    tick();
    chk("cnt_max", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("cnt_wrap", stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall and forwarding controller for the five-stage pipeline. It compares source-register demand in D against pending writes in E, M and W, and drives the stall, bubble and forward-select signals that sequence the F/D/E/M/W pipeline registers. It also owns the busy sequencer of the multi-cycle multiply/divide unit and holds a performance counter of stall cycles.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `D_rs`, `D_rt` input 5: source registers of the instruction in D.
- `D_Tuse_rs`, `D_Tuse_rt` input 2: cycles until use; 3 means unused.
- `D_md` input 1: D holds an md-class instruction (mult/div/mfhi/mflo/mthi/mtlo).
- `E_A3`, `M_A3`, `W_A3` input 5: destination registers per stage; 0 means no write.
- `E_Tnew`, `M_Tnew` input 2: cycles until the result is available in that stage.
- `E_rs`, `E_rt`, `M_rt` input 5: source registers of the later stages, used for forwarding.
- `E_md_start` input 1: one-cycle pulse while a mult/div is in E.
- `E_md_div` input 1: qualifies `E_md_start`; 1 means div/divu.
- `stall` output 1: freeze the PC and the D register.
- `E_flush` output 1: load a bubble into the E register.
- `md_busy` output 1: the md unit is occupied.
- `D_fwd_rs`, `D_fwd_rt` output 2: forward select; 0 = register file, 1 = E, 2 = M, 3 = W.
- `E_fwd_rs`, `E_fwd_rt` output 2: same encoding; only M and W are valid sources.
- `M_fwd_rt` output 1: 1 selects the W forward.
- `stall_cnt` output 32: number of cycles with `stall` asserted.

## Operation
- Data stall: asserted when either of these holds for `rs` or `rt` (for `rt`, substitute `D_rt`/`D_Tuse_rt`):
  - `D_rs != 0 && D_rs == E_A3 && E_Tnew > D_Tuse_rs`
  - `D_rs != 0 && D_rs == M_A3 && M_Tnew > D_Tuse_rs`
- W never causes a stall.
- MD stall: asserted when `D_md && (md_busy || E_md_start)`.
- `stall = data_stall | md_stall`.
- `E_flush = stall`.
- Forward priority: the nearest stage wins, in the order E, then M, then W.
  - A stage qualifies only if its A3 is nonzero, matches the source register, and its Tnew is 0. W is always Tnew 0.
  - Register 0 never forwards.
- MD sequencer has 2 states, IDLE and BUSY, with a 4-bit (minimum) down-counter `cnt`.
  - IDLE with `E_md_start` → BUSY; `cnt` loads `DIV_CYCLES` if `E_md_div`, else `MULT_CYCLES`.
  - BUSY: `cnt` decrements each cycle; at `cnt == 1` → IDLE.
  - `E_md_start` while BUSY cannot occur, because md stall prevents it. If it is asserted anyway, ignore it.
  - `md_busy` is 1 exactly when the state is BUSY.
- `stall_cnt` increments on each rising edge where `stall == 1`. It wraps from 0xFFFF_FFFF to 0.

## Timing
- `stall`, `E_flush` and all forward selects are combinational from the inputs and `md_busy`, with zero latency.
- On a start at edge t, `md_busy` is high for exactly N cycles: from edge t+1 up to, but not including, edge t+1+N.
- An md instruction waiting in D is held from the cycle of `E_md_start` through the last busy cycle. It advances on the first edge after `md_busy` falls.
- Reset values while `reset == 0`: state IDLE, `cnt = 0`, `md_busy = 0`, `stall_cnt = 0`.
- Combinational outputs follow their inputs even during reset.
- Reset asserted mid-BUSY drops `md_busy` immediately (asynchronous). The pending operation is abandoned.
- Simultaneous data and md stall conditions produce one stall; `stall_cnt` increments once.

## Structure
- A shared package `pipe_defs` holds:
  - the forward-select encodings `FWD_RF`, `FWD_E`, `FWD_M`, `FWD_W`;
  - `TUSE_NONE = 3`;
  - the defaults for `MULT_CYCLES` and `DIV_CYCLES`;
  - `PC_DEFAULT`.
- One sub-module, `md_busy_seq`: the IDLE/BUSY FSM and counter. The top level instantiates it once.

## Test plan
- `E_A3 = 8`, `E_Tnew = 2`, `D_rs = 8`, `D_Tuse_rs = 0` → `stall = 1`, `E_flush = 1`, and `stall_cnt` increments by 1 per cycle held.
- `E_A3 = 8` with `E_Tnew = 0`, `M_A3 = 8`, `D_rs = 8` → `D_fwd_rs = 1` (E beats M), `stall = 0`.
- `D_rs = 0` with `E_A3 = 0`, `E_Tnew = 2` → `stall = 0`, `D_fwd_rs = 0`.
- `E_md_start = 1`, `E_md_div = 0`, then `D_md = 1` → `stall` high for 6 cycles (the start cycle plus 5 busy cycles); `md_busy` high exactly 5 cycles.
- Div start, then `reset` pulled low after 3 busy cycles → `md_busy = 0` and `stall_cnt = 0` before the next edge. After release, the FSM is IDLE and the next start behaves normally.
- Preload `stall_cnt` to 0xFFFF_FFFF via sustained stall (or force), then one more stall cycle → `stall_cnt = 0`.
